// File: rtl/arb_weighted_rr_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Holds the FSM state encoding and the zero-weight rule.
package arb_weighted_rr_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // A programmed weight of zero still earns one grant per round.
  function automatic int unsigned arb_eff_weight(
    input int unsigned w
  );
    return (w == 0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/arb_weighted_rr_picker.sv
// Combinational rotating first-set-bit picker.
// Ports: cand_i candidates, ptr_i start index, gnt_o one-hot pick.
module arb_rr_picker #(
  parameter int P_REQUESTER_NUM = 3,
  parameter int P_PTR_W = $clog2(P_REQUESTER_NUM)
) (
  input  logic [P_REQUESTER_NUM-1:0] cand_i,
  input  logic [P_PTR_W-1:0]         ptr_i,
  output logic [P_REQUESTER_NUM-1:0] gnt_o
);

  localparam int N = P_REQUESTER_NUM;

  logic [N-1:0] lo_mask;
  logic [N-1:0] hi;
  logic [N-1:0] sel;

  // Prefer candidates at or above the pointer; otherwise wrap
  // to the lowest candidate. x & -x isolates the lowest set bit.
  always_comb begin
    lo_mask = (N'(1) << ptr_i) - N'(1);
    hi      = cand_i & ~lo_mask;
    sel     = (|hi) ? hi : cand_i;
    gnt_o   = sel & (~sel + N'(1));
  end

endmodule

// File: rtl/arb_weighted_rr.sv
// Weighted round-robin arbiter with registered, held one-hot grant.
// Ports: request/weight/grant_ready in; grant/valid/done/ptr out.
module arb_weighted_rr
  import arb_weighted_rr_pkg::*;
#(
  parameter int P_REQUESTER_NUM = 3,
  parameter int P_WEIGHT_W = 4,
  parameter int P_PTR_W = $clog2(P_REQUESTER_NUM)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [P_REQUESTER_NUM-1:0]        request,
  input  logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] weight,
  input  logic                              grant_ready,
  output logic [P_REQUESTER_NUM-1:0]        grant,
  output logic                              grant_valid,
  output logic [P_REQUESTER_NUM-1:0]        request_weight_completed,
  output logic [P_PTR_W-1:0]                prior_ptr
);

  localparam int N = P_REQUESTER_NUM;
  localparam int W = P_WEIGHT_W;

  arb_state_e   state_q, state_d;
  logic [N-1:0] grant_q, grant_d;
  logic [N-1:0] done_q, done_d;
  logic [W-1:0] cnt_q [N];
  logic [W-1:0] cnt_d [N];
  logic [P_PTR_W-1:0] ptr_q, ptr_d;

  logic [W-1:0] wt [N];
  logic [N-1:0] cand_raw;
  logic         restart;
  logic [N-1:0] cand;
  logic [N-1:0] pick;
  logic [P_PTR_W-1:0] gidx;
  logic [W-1:0] cnt_g;
  logic [W-1:0] wt_g;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      wt[k] = weight[k*W +: W];
    end
  end

  // Once every requester still asking has finished its weight,
  // a new round starts from the raw request vector.
  assign cand_raw = request & ~done_q;
  assign restart  = ~|cand_raw;
  assign cand     = restart ? request : cand_raw;

  arb_rr_picker #(
    .P_REQUESTER_NUM(N),
    .P_PTR_W(P_PTR_W)
  ) u_picker (
    .cand_i(cand),
    .ptr_i (ptr_q),
    .gnt_o (pick)
  );

  always_comb begin
    gidx = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_q[k]) gidx = P_PTR_W'(k);
    end
  end

  assign cnt_g = cnt_q[gidx];
  assign wt_g  = wt[gidx];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (|request) begin
          if (restart) begin
            done_d = '0;
            for (int k = 0; k < N; k++) begin
              cnt_d[k] = '0;
            end
          end
          grant_d = pick;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (grant_ready) begin
          if (32'(cnt_g) + 32'd1 >=
              arb_eff_weight(32'(wt_g))) begin
            done_d[gidx] = 1'b1;
            cnt_d[gidx]  = '0;
            if (gidx == P_PTR_W'(N - 1)) begin
              ptr_d = '0;
            end else begin
              ptr_d = gidx + P_PTR_W'(1);
            end
          end else begin
            cnt_d[gidx] = cnt_g + W'(1);
          end
          grant_d = '0;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      ptr_q   <= '0;
      for (int k = 0; k < N; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant                    = grant_q;
  assign grant_valid              = (state_q == ARB_GRANT);
  assign request_weight_completed = done_q;
  assign prior_ptr                = ptr_q;

endmodule

// File: tb/tb_arb_weighted_rr.sv
// Self-checking bench for arb_weighted_rr against a behavioural model.
// Directed scenarios plus randomized traffic, checked every cycle.
module tb_arb_weighted_rr;

  localparam int N  = 3;
  localparam int W  = 4;
  localparam int PW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   request;
  logic [N*W-1:0] weight;
  logic           grant_ready;
  logic [N-1:0]   grant;
  logic           grant_valid;
  logic [N-1:0]   request_weight_completed;
  logic [PW-1:0]  prior_ptr;

  arb_weighted_rr #(
    .P_REQUESTER_NUM(N),
    .P_WEIGHT_W(W),
    .P_PTR_W(PW)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .request                 (request),
    .weight                  (weight),
    .grant_ready             (grant_ready),
    .grant                   (grant),
    .grant_valid             (grant_valid),
    .request_weight_completed(request_weight_completed),
    .prior_ptr               (prior_ptr)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Model: who holds the resource, per-requester usage this round,
  // which requesters finished their share, and the priority index.
  bit     m_busy;
  int     m_owner;
  int     m_used [N];
  bit     m_fin  [N];
  int     m_ptr;
  int     acc_q [$];
  int     ptr_q [$];
  int     dut_q [$];

  function automatic int wof(input logic [N*W-1:0] wv, input int i);
    int v;
    v = int'((wv >> (i * W)) & 12'hF);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v == N'(1 << i)) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_owner = 0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) begin
      m_used[i] = 0;
      m_fin[i] = 0;
    end
  endtask

  task automatic model_step();
    bit any;
    if (!rst_n) begin
      model_reset();
    end else if (!m_busy) begin
      if (request != 0) begin
        any = 0;
        for (int i = 0; i < N; i++)
          if (request[i] && !m_fin[i]) any = 1;
        if (!any) begin
          for (int i = 0; i < N; i++) begin
            m_fin[i] = 0;
            m_used[i] = 0;
          end
        end
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (request[i] && !m_fin[i]) begin
            m_owner = i;
            break;
          end
        end
        m_busy = 1;
      end
    end else if (grant_ready) begin
      m_used[m_owner]++;
      if (m_used[m_owner] >= wof(weight, m_owner)) begin
        m_fin[m_owner] = 1;
        m_used[m_owner] = 0;
        m_ptr = (m_owner + 1) % N;
      end
      acc_q.push_back(m_owner);
      ptr_q.push_back(m_ptr);
      m_busy = 0;
    end
  endtask

  task automatic check_vec();
    logic [N-1:0] eg;
    logic [N-1:0] ed;
    eg = m_busy ? N'(1 << m_owner) : '0;
    for (int i = 0; i < N; i++) ed[i] = m_fin[i];
    vecs++;
    if (grant !== eg || grant_valid !== m_busy ||
        request_weight_completed !== ed || prior_ptr !== PW'(m_ptr)) begin
      errs++;
      $display("FAIL cycle t=%0t grant=%b/%b valid=%b/%b done=%b/%b ptr=%0d/%0d (got/exp)",
               $time, grant, eg, grant_valid, m_busy,
               request_weight_completed, ed, prior_ptr, m_ptr);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    if (rst_n && grant_valid && grant_ready)
      dut_q.push_back(onehot_idx(grant));
    @(posedge clk);
    model_step();
    #1;
    check_vec();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) cycle();
    rst_n = 1'b1;
    acc_q.delete();
    ptr_q.delete();
    dut_q.delete();
  endtask

  task automatic run_ready(input int n);
    for (int i = 0; i < n; i++) begin
      grant_ready = m_busy;
      cycle();
    end
  endtask

  initial begin
    int g0;
    int nacc;
    model_reset();
    rst_n = 1'b0;
    request = '0;
    weight = '0;
    grant_ready = 1'b0;

    // Reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      request = N'($urandom);
      weight = (N*W)'($urandom);
      grant_ready = 1'($urandom);
      cycle();
    end
    chk("reset_grant", int'(grant), 0);
    chk("reset_valid", int'(grant_valid), 0);
    chk("reset_done", int'(request_weight_completed), 0);
    chk("reset_ptr", int'(prior_ptr), 0);

    // Weights {2,1,3}, all requesting
    do_reset(1);
    weight = 12'h312;
    request = 3'b111;
    run_ready(18);
    chk("wrr_nacc", dut_q.size(), 9);
    begin
      int exp_ord [9] = '{0, 0, 1, 2, 2, 2, 0, 0, 1};
      for (int i = 0; i < 9; i++)
        chk($sformatf("wrr_order%0d", i),
            (i < dut_q.size()) ? dut_q[i] : -1, exp_ord[i]);
    end
    chk("model_order", (acc_q.size() > 5) ? acc_q[5] : -1, 2);
    chk("ptr_after_g0", (ptr_q.size() > 1) ? ptr_q[1] : -1, 1);
    chk("ptr_after_g1", (ptr_q.size() > 2) ? ptr_q[2] : -1, 2);
    chk("ptr_after_g2", (ptr_q.size() > 5) ? ptr_q[5] : -1, 0);

    // Single requester, weight 1
    do_reset(1);
    weight = 12'h111;
    request = 3'b010;
    for (int i = 0; i < 4; i++) begin
      grant_ready = 1'b0;
      cycle();
      chk("single_grant", int'(grant), 2);
      chk("single_done_pre", int'(request_weight_completed), 0);
      grant_ready = 1'b1;
      cycle();
      chk("single_done_post", int'(request_weight_completed), 2);
    end
    chk("single_nacc", dut_q.size(), 4);

    // Backpressure
    do_reset(1);
    weight = 12'h222;
    request = 3'b111;
    grant_ready = 1'b0;
    cycle();
    g0 = int'(grant);
    chk("bp_first", g0, 1);
    nacc = acc_q.size();
    for (int i = 0; i < 5; i++) begin
      request = N'($urandom);
      cycle();
      chk("bp_hold", int'(grant), g0);
    end
    request = 3'b111;
    grant_ready = 1'b1;
    cycle();
    chk("bp_released", int'(grant_valid), 0);
    grant_ready = 1'b0;
    cycle();
    chk("bp_one_accept", acc_q.size() - nacc, 1);
    chk("bp_regrant", int'(grant), 1);

    // weight[0]=0 behaves as weight 1
    do_reset(1);
    weight = 12'h200;
    request = 3'b101;
    run_ready(12);
    begin
      int exp_ord [6] = '{0, 2, 2, 0, 2, 2};
      chk("w0_nacc", dut_q.size(), 6);
      for (int i = 0; i < 6; i++)
        chk($sformatf("w0_order%0d", i),
            (i < dut_q.size()) ? dut_q[i] : -1, exp_ord[i]);
    end

    // Reset mid-GRANT
    do_reset(1);
    weight = 12'h111;
    request = 3'b111;
    run_ready(4);
    grant_ready = 1'b0;
    cycle();
    chk("mid_grant", int'(grant), 4);
    chk("mid_done", int'(request_weight_completed), 3);
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_grant", int'(grant), 0);
    chk("mid_rst_valid", int'(grant_valid), 0);
    chk("mid_rst_done", int'(request_weight_completed), 0);
    chk("mid_rst_ptr", int'(prior_ptr), 0);
    rst_n = 1'b1;
    request = 3'b110;
    cycle();
    chk("mid_next", int'(grant), 2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 9) == 0) weight = (N*W)'($urandom);
      request = N'($urandom);
      grant_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
